prbs_rng_server: RTL

Shared random-number server that arbitrates one PRBS LFSR among `NREQ` requesters with round-robin fairness. On each grant it advances the LFSR by `STEPS` shifts, so consecutive consumers never see overlapping bit windows. It then delivers the fresh `N`-bit word together with a one-cycle grant. It sits between the core's I/O slots (game logic, noise/dither generators, test pattern sources) and the single LFSR, and also provides a software reseed path.

---
 rtl/prbs_pkg.sv | 26 ++
 rtl/prbs_lfsr_core.sv | 27 ++
 rtl/prbs_rng_server.sv | 104 ++++++++++
 3 files changed

// File: rtl/prbs_pkg.sv
// Shared types and constants for the PRBS random-number server:
// FSM encoding, LFSR start value, tap positions and seed sanitising.
package prbs_pkg;

    localparam int LFSR_W = 14;

    // x^14 + x^5 + x^3 + x + 1, expressed as register bit positions
    localparam int TAP3 = 13;
    localparam int TAP2 = 4;
    localparam int TAP1 = 2;
    localparam int TAP0 = 0;

    localparam logic [LFSR_W-1:0] START = {{(LFSR_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADVANCE,
        ST_GRANT
    } state_t;

    // The all-zero state is a lock-up point of the LFSR, so it is never loaded.
    function automatic logic [LFSR_W-1:0] seed_fix(input logic [LFSR_W-1:0] s);
        return (s == '0) ? START : s;
    endfunction

endpackage

// File: rtl/prbs_lfsr_core.sv
// PRBS LFSR register with step enable and parallel load; load wins over step.
module prbs_lfsr_core
    import prbs_pkg::*;
#(
    parameter int N = LFSR_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] q
);

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= START;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            q <= {q[N-2:0], q[TAP3] ^ q[TAP2] ^ q[TAP1] ^ q[TAP0]};
        end
    end

endmodule

// File: rtl/prbs_rng_server.sv
// Round-robin server sharing one PRBS LFSR among NREQ requesters; each grant
// follows STEPS fresh shifts so consumers never share bit windows.
module prbs_rng_server
    import prbs_pkg::*;
#(
    parameter int N     = LFSR_W,
    parameter int NREQ  = 4,
    parameter int STEPS = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    output logic [NREQ-1:0] gnt,
    output logic [N-1:0]    rnd_data,
    input  logic            seed_wr,
    input  logic [N-1:0]    seed_data,
    output logic            busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(STEPS + 1);

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [PW-1:0]   ptr;
    logic [PW-1:0]   winner;
    logic [PW-1:0]   pick;
    logic            pick_vld;

    prbs_lfsr_core #(.N(N)) u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .en       (state == ST_ADVANCE),
        .load     (seed_wr),
        .load_val (seed_fix(seed_data)),
        .q        (rnd_data)
    );

    // Descending scan so the requester closest after ptr overrides the rest.
    // NOTE: every combinational output gets a default first, so no path
    // through the block can leave it unassigned and infer a latch.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = NREQ; i >= 1; i--) begin
            if (req[(int'(ptr) + i) % NREQ]) begin
                pick     = PW'((int'(ptr) + i) % NREQ);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (!seed_wr && pick_vld) state_nxt = ST_ADVANCE;
            ST_ADVANCE: if (seed_wr)              state_nxt = ST_IDLE;
                        else if (cnt == '0)       state_nxt = ST_GRANT;
            ST_GRANT:   state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt  = '0;
        busy = (state != ST_IDLE);
        if (state == ST_GRANT) gnt[winner] = 1'b1;
    end

    // A seed during ADVANCE abandons the winner; ptr moves only on a completed grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            ptr    <= PW'(NREQ - 1);
            winner <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!seed_wr && pick_vld) begin
                        winner <= pick;
                        cnt    <= CW'(STEPS - 1);
                    end
                end
                ST_ADVANCE: begin
                    if (!seed_wr && cnt != '0) cnt <= cnt - CW'(1);
                end
                ST_GRANT: begin
                    ptr <= winner;
                end
                default: ;
            endcase
        end
    end

endmodule
